// File: rtl/ppt_seq_pkg.sv
// Shared types and constants for the PPT burst sequencer: FSM states and the
// byte layout of a burst descriptor slot.
package ppt_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        GAP,
        DONE
    } state_t;

    localparam int unsigned OFF_PER    = 0;
    localparam int unsigned OFF_WID    = 2;
    localparam int unsigned OFF_CNT    = 4;
    localparam int unsigned OFF_GAP    = 6;
    localparam int unsigned SLOT_BYTES = 8;
    localparam int unsigned RUN_BLANK  = 2;

endpackage

// File: rtl/ppt_slot_table.sv
// Byte-writable descriptor table (period/width/count/gap per slot) with a
// combinational byte readback and a combinational full-slot read port.
module ppt_slot_table
    import ppt_seq_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int DW        = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_SLOTS)+2:0]   cfg_addr,
    input  logic [7:0]                     cfg_wdata,
    output logic [7:0]                     cfg_rdata,
    input  logic [$clog2(NUM_SLOTS)-1:0]   rd_slot,
    output logic [DW-1:0]                  rd_period,
    output logic [DW-1:0]                  rd_width,
    output logic [DW-1:0]                  rd_count,
    output logic [DW-1:0]                  rd_gap
);

    logic [7:0]  mem [NUM_SLOTS*SLOT_BYTES];
    logic [15:0] per16, wid16, cnt16, gap16;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (cfg_we) begin
            mem[cfg_addr] <= cfg_wdata;
        end
    end

    assign cfg_rdata = mem[cfg_addr];

    // Each field is a lo/hi byte pair; fields are at most 16 bits wide.
    always_comb begin
        per16 = {mem[{rd_slot, 3'(OFF_PER + 1)}], mem[{rd_slot, 3'(OFF_PER)}]};
        wid16 = {mem[{rd_slot, 3'(OFF_WID + 1)}], mem[{rd_slot, 3'(OFF_WID)}]};
        cnt16 = {mem[{rd_slot, 3'(OFF_CNT + 1)}], mem[{rd_slot, 3'(OFF_CNT)}]};
        gap16 = {mem[{rd_slot, 3'(OFF_GAP + 1)}], mem[{rd_slot, 3'(OFF_GAP)}]};
    end

    assign rd_period = per16[DW-1:0];
    assign rd_width  = wid16[DW-1:0];
    assign rd_count  = cnt16[DW-1:0];
    assign rd_gap    = gap16[DW-1:0];

endmodule

// File: rtl/ppt_burst_sequencer.sv
// Steps through a table of burst descriptors, driving the PPT generator/counter
// configuration, waiting for done and the inter-burst gap, with optional repeats.
module ppt_burst_sequencer
    import ppt_seq_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int DW        = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_SLOTS)+2:0]   cfg_addr,
    input  logic [7:0]                     cfg_wdata,
    output logic [7:0]                     cfg_rdata,
    input  logic                           start,
    input  logic                           abort,
    input  logic [$clog2(NUM_SLOTS)-1:0]   seq_last,
    input  logic [7:0]                     loops,
    output logic [DW-1:0]                  ppt_period,
    output logic [DW-1:0]                  ppt_width,
    output logic [DW-1:0]                  ppt_count,
    output logic                           ppt_run,
    input  logic                           ppt_done,
    output logic                           busy,
    output logic [$clog2(NUM_SLOTS)-1:0]   cur_slot,
    output logic [7:0]                     loops_left,
    output logic                           seq_done,
    output logic                           aborted
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int BW = $clog2(RUN_BLANK + 1);

    state_t          state, state_nx;
    logic [SW-1:0]   seq_last_q;
    logic [7:0]      loops_q;
    logic [DW-1:0]   gap_ctr;
    logic [BW-1:0]   blank_ctr;
    logic [DW-1:0]   tbl_period, tbl_width, tbl_count, tbl_gap;
    logic            slot_skip, last_slot, repeat_seq, blank_done, slot_exit;

    ppt_slot_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .DW        (DW)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .rd_slot   (cur_slot),
        .rd_period (tbl_period),
        .rd_width  (tbl_width),
        .rd_count  (tbl_count),
        .rd_gap    (tbl_gap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The NEXT decision is folded into the LOAD-skip and GAP-expiry cycles.
    always_comb begin
        slot_skip  = (tbl_period == '0) || (tbl_count == '0);
        last_slot  = (cur_slot == seq_last_q);
        repeat_seq = (loops_q == '0) || (loops_left > 8'd1);
        blank_done = (blank_ctr == BW'(RUN_BLANK));
        slot_exit  = 1'b0;
        state_nx   = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (slot_skip) slot_exit = 1'b1;
                     else           state_nx  = RUN;
            RUN:     if (blank_done && ppt_done) state_nx = GAP;
            GAP:     if (gap_ctr == '0) slot_exit = 1'b1;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (slot_exit) begin
            state_nx = (last_slot && !repeat_seq) ? DONE : LOAD;
        end
        if (abort) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        ppt_run  = (state == RUN);
        seq_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_last_q <= '0;
            loops_q    <= '0;
            cur_slot   <= '0;
            loops_left <= '0;
            ppt_period <= '0;
            ppt_width  <= '0;
            ppt_count  <= '0;
            gap_ctr    <= '0;
            blank_ctr  <= '0;
            aborted    <= 1'b0;
        end else begin
            aborted <= abort && (state != IDLE);
            if (!abort) begin
                case (state)
                    IDLE: if (start) begin
                        seq_last_q <= seq_last;
                        loops_q    <= loops;
                        cur_slot   <= '0;
                        loops_left <= loops;
                    end
                    LOAD: if (!slot_skip) begin
                        ppt_period <= tbl_period;
                        ppt_width  <= tbl_width;
                        ppt_count  <= tbl_count;
                        blank_ctr  <= '0;
                    end
                    RUN: begin
                        if (!blank_done) blank_ctr <= blank_ctr + BW'(1);
                        if (blank_done && ppt_done) gap_ctr <= tbl_gap;
                    end
                    GAP: if (gap_ctr != '0) gap_ctr <= gap_ctr - DW'(1);
                    default: ;
                endcase
                if (slot_exit) begin
                    if (!last_slot) begin
                        cur_slot <= cur_slot + SW'(1);
                    end else begin
                        if (repeat_seq) cur_slot <= '0;
                        if (loops_left != '0) loops_left <= loops_left - 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ppt_burst_sequencer.sv
// Self-checking bench: directed scenarios plus randomized descriptor tables
// compared against a timeline model derived from the descriptor rules.
module tb_ppt_burst_sequencer;

    localparam int NS = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [4:0]    cfg_addr = '0;
    logic [7:0]    cfg_wdata = '0;
    logic [7:0]    cfg_rdata;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    seq_last = '0;
    logic [7:0]    loops = '0;
    logic [DW-1:0] ppt_period, ppt_width, ppt_count;
    logic          ppt_run;
    logic          ppt_done = 1'b0;
    logic          busy;
    logic [1:0]    cur_slot;
    logic [7:0]    loops_left;
    logic          seq_done;
    logic          aborted;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [7:0]    tb_mem [NS*8];
    int            run_cnt = 0;
    bit            stale_done = 1'b0;

    ppt_burst_sequencer #(
        .NUM_SLOTS (NS),
        .DW        (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .start      (start),
        .abort      (abort),
        .seq_last   (seq_last),
        .loops      (loops),
        .ppt_period (ppt_period),
        .ppt_width  (ppt_width),
        .ppt_count  (ppt_count),
        .ppt_run    (ppt_run),
        .ppt_done   (ppt_done),
        .busy       (busy),
        .cur_slot   (cur_slot),
        .loops_left (loops_left),
        .seq_done   (seq_done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and update the counter model: done rises
    // once run has been high for period*count cycles, and clears while run is low.
    task automatic tick();
        @(negedge clk);
        if (!ppt_run) begin
            run_cnt = 0;
            ppt_done = stale_done;
        end else begin
            run_cnt++;
            ppt_done = stale_done || (run_cnt >= int'(ppt_period) * int'(ppt_count));
        end
    endtask

    function automatic int fld(input int s, input int off);
        return int'({tb_mem[s*8+off+1], tb_mem[s*8+off]});
    endfunction

    task automatic wr_byte(input int a, input int d);
        cfg_we    = 1'b1;
        cfg_addr  = 5'(a);
        cfg_wdata = 8'(d);
        tb_mem[a] = 8'(d);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic wr_slot(input int s, input int per, input int wid, input int cnt, input int gap);
        int v[4];
        v = '{per, wid, cnt, gap};
        for (int f = 0; f < 4; f++) begin
            wr_byte(s*8 + 2*f,     v[f] & 8'hff);
            wr_byte(s*8 + 2*f + 1, (v[f] >> 8) & 8'hff);
        end
    endtask

    task automatic wait_run(input logic lvl, input int budget, input string tag);
        for (int c = 0; c < budget && ppt_run !== lvl; c++) tick();
        check(tag, 32'(ppt_run), 32'(lvl));
    endtask

    // Expected timeline: each burst is preceded by (pending low cycles + its LOAD);
    // skipped slots cost one LOAD each; a burst leaves gap+1 low cycles behind it.
    task automatic run_seq(input int sl, input int lp);
        int q_slot[$], q_low[$], q_len[$], q_ll[$], q_per[$], q_wid[$], q_cnt[$];
        int pend, tail, n_exp, n_burst, low, len, cur_len;
        bit in_run, finished;
        pend = 0;
        for (int p = 0; p < lp; p++) begin
            for (int s = 0; s <= sl; s++) begin
                if (fld(s, 0) == 0 || fld(s, 4) == 0) begin
                    pend += 1;
                end else begin
                    q_slot.push_back(s);
                    q_low.push_back(pend + 1);
                    q_len.push_back(stale_done ? 3 : ((fld(s,0)*fld(s,4) < 3) ? 3 : fld(s,0)*fld(s,4)));
                    q_ll.push_back(lp - p);
                    q_per.push_back(fld(s, 0));
                    q_wid.push_back(fld(s, 2));
                    q_cnt.push_back(fld(s, 4));
                    pend = fld(s, 6) + 1;
                end
            end
        end
        tail  = pend + 1;
        n_exp = q_slot.size();

        seq_last = 2'(sl);
        loops    = 8'(lp);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        n_burst = 0; low = 0; len = 0; cur_len = 0; in_run = 0; finished = 0;
        for (int c = 0; c < 20000 && !finished; c++) begin
            if (ppt_run) begin
                if (!in_run) begin
                    n_burst++;
                    if (q_slot.size() != 0) begin
                        check("burst_slot",  32'(cur_slot),   32'(q_slot.pop_front()));
                        check("low_before",  32'(low),        32'(q_low.pop_front()));
                        check("burst_period",32'(ppt_period), 32'(q_per.pop_front()));
                        check("burst_width", 32'(ppt_width),  32'(q_wid.pop_front()));
                        check("burst_count", 32'(ppt_count),  32'(q_cnt.pop_front()));
                        check("loops_left",  32'(loops_left), 32'(q_ll.pop_front()));
                        cur_len = q_len.pop_front();
                    end
                    in_run = 1;
                    len = 0;
                end
                len++;
            end else begin
                if (in_run) begin
                    check("run_len", 32'(len), 32'(cur_len));
                    in_run = 0;
                    low = 0;
                end
                if (busy) low++;
                if (seq_done) begin
                    check("tail_low", 32'(low), 32'(tail));
                    finished = 1;
                end
            end
            if (!finished) tick();
        end
        check("seq_finished", 32'(finished), 32'd1);
        check("burst_total", 32'(n_burst), 32'(n_exp));
        tick();
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(seq_done), 32'd0);
        check("done_loops_left", 32'(loops_left), 32'd0);
        check("done_no_abort", 32'(aborted), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NS*8; i++) tb_mem[i] = '0;
        tick();
        tick();
        // reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_run", 32'(ppt_run), 32'd0);
        check("rst_period", 32'(ppt_period), 32'd0);
        check("rst_loops_left", 32'(loops_left), 32'd0);
        rst = 1'b0;
        tick();
        for (int a = 0; a < NS*8; a += 3) begin
            cfg_addr = 5'(a);
            #1 check("rst_table", 32'(cfg_rdata), 32'd0);
        end

        // single slot
        wr_slot(0, 10, 3, 4, 5);
        cfg_addr = 5'd4;
        #1 check("readback_cnt", 32'(cfg_rdata), 32'd4);
        run_seq(0, 1);

        // two slots, three passes
        wr_slot(0, 3, 1, 2, 1);
        wr_slot(1, 2, 1, 5, 0);
        run_seq(1, 3);

        // skipped middle slot
        wr_slot(0, 2, 1, 2, 0);
        wr_slot(1, 4, 1, 0, 3);
        wr_slot(2, 5, 2, 1, 2);
        run_seq(2, 1);

        // stale done held high
        stale_done = 1'b1;
        run_seq(2, 2);
        stale_done = 1'b0;
        tick();

        // randomized tables
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < NS; s++) begin
                wr_slot(s, $urandom_range(0, 3), $urandom_range(0, 300),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            end
            cfg_addr = 5'($urandom_range(0, NS*8-1));
            #1 check("rand_readback", 32'(cfg_rdata), 32'(tb_mem[cfg_addr]));
            run_seq($urandom_range(0, NS-1), $urandom_range(1, 3));
        end

        // abort in RUN cycle 7
        wr_slot(0, 10, 3, 4, 5);
        seq_last = 2'd0;
        loops = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run(1'b1, 50, "abort_run_seen");
        repeat (6) tick();
        check("abort_still_run", 32'(ppt_run), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_run", 32'(ppt_run), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pulse", 32'(aborted), 32'd1);
        check("abort_no_done", 32'(seq_done), 32'd0);
        tick();
        check("abort_pulse_end", 32'(aborted), 32'd0);

        // start and abort together from IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_aborted", 32'(aborted), 32'd0);
        tick();
        check("sa_busy2", 32'(busy), 32'd0);

        // infinite loops over an all-skipped table spins until abort
        wr_slot(0, 5, 1, 0, 0);
        seq_last = 2'd0;
        loops = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("spin_busy", 32'(busy), 32'd1);
        check("spin_run", 32'(ppt_run), 32'd0);
        check("spin_loops_left", 32'(loops_left), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("spin_aborted", 32'(aborted), 32'd1);
        check("spin_busy_end", 32'(busy), 32'd0);

        // mid-run rewrite, then async reset during GAP
        wr_slot(0, 7, 2, 3, 4);
        seq_last = 2'd0;
        loops = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_run(1'b1, 20, "rw_run1");
        wr_byte(0, 99);
        wr_byte(1, 0);
        check("rw_period_held", 32'(ppt_period), 32'd7);
        cfg_addr = 5'd0;
        #1 check("rw_readback", 32'(cfg_rdata), 32'd99);
        wait_run(1'b0, 40, "rw_fall1");
        wait_run(1'b1, 20, "rw_run2");
        check("rw_period_new", 32'(ppt_period), 32'd99);
        check("rw_loops_left", 32'(loops_left), 32'd1);
        wait_run(1'b0, 400, "rw_fall2");
        tick();
        tick();
        check("gap_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_run", 32'(ppt_run), 32'd0);
        check("arst_period", 32'(ppt_period), 32'd0);
        check("arst_width", 32'(ppt_width), 32'd0);
        check("arst_count", 32'(ppt_count), 32'd0);
        check("arst_loops_left", 32'(loops_left), 32'd0);
        check("arst_cur_slot", 32'(cur_slot), 32'd0);
        check("arst_seq_done", 32'(seq_done), 32'd0);
        check("arst_aborted", 32'(aborted), 32'd0);
        cfg_addr = 5'd0;
        #1 check("arst_table0", 32'(cfg_rdata), 32'd0);
        cfg_addr = 5'd4;
        #1 check("arst_table4", 32'(cfg_rdata), 32'd0);
        for (int i = 0; i < NS*8; i++) tb_mem[i] = '0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
